reg_bus_sequencer: RTL

- Sequences register-to-register transfers over the shared 8-bit tri-state bus formed by the reg8b_3state-style registers.
- Generates the active-low per-register output-enable strobes (rd_bar) and load strobes (wr_bar), plus an external-driver enable.
- Only one driver is ever enabled on the bus at a time.
- Requesters issue {src, dst} transfers through a valid/ready handshake.

---
 rtl/reg_bus_pkg.sv | 8 +
 rtl/onehot_bar_dec.sv | 13 +
 rtl/reg_bus_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: sequencer state encoding, idle strobe level and index-width helper
package reg_bus_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, TURN} state_e;
    localparam logic [15:0] STROBE_IDLE = '1;
    function automatic int idx_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/onehot_bar_dec.sv
// onehot_bar_dec: active-low one-hot decode of idx; all ones while en is low
module onehot_bar_dec
    import reg_bus_pkg::*;
#(
    parameter int NREG = 4,
    parameter int IDXW = idx_w(NREG)
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [NREG-1:0] out_bar
);
    always_comb out_bar = en ? ~(NREG'(1) << idx) : STROBE_IDLE[NREG-1:0];
endmodule

// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: sequences tri-state bus register transfers with registered active-low strobes
// Define REG_BUS_TURNAROUND_EN to add an idle bus (TURN) cycle after every load.
module reg_bus_sequencer
    import reg_bus_pkg::*;
#(
    parameter int NREG = 4,
    parameter int IDXW = idx_w(NREG)
) (
    input  logic            clk,
    input  logic            rst_bar,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [IDXW-1:0] req_src,
    input  logic [IDXW-1:0] req_dst,
    input  logic            req_ext,
    output logic [NREG-1:0] rd_bar,
    output logic [NREG-1:0] wr_bar,
    output logic            ext_oe_bar,
    output logic            busy,
    output logic            done,
    output logic            err
);
    state_e          state_q, state_d;
    logic [IDXW-1:0] src_q, src_d, dst_q, dst_d;
    logic            ext_q, ext_d;
    logic [NREG-1:0] rd_bar_q, rd_bar_d, wr_bar_q, wr_bar_d;
    logic            ext_oe_bar_q, ext_oe_bar_d, done_q, done_d, err_q, err_d;
    logic            accept, rej, src_on;

    always_comb begin
        accept = req_valid && req_ready;
        rej    = int'(req_dst) >= NREG || (!req_ext && (int'(req_src) >= NREG || req_src == req_dst));
        src_d  = accept ? req_src : src_q;
        dst_d  = accept ? req_dst : dst_q;
        ext_d  = accept ? req_ext : ext_q;
        case (state_q)
            IDLE:    state_d = (accept && !rej) ? DRIVE : IDLE;
            DRIVE:   state_d = LATCH;
`ifdef REG_BUS_TURNAROUND_EN
            LATCH:   state_d = TURN;
`else
            LATCH:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        // Strobes are computed from the next state so they appear in the first cycle of that state.
        src_on       = state_d == DRIVE || state_d == LATCH;
        ext_oe_bar_d = !(src_on && ext_d);
        done_d       = state_q == LATCH;
        err_d        = accept && rej;
    end

    onehot_bar_dec #(.NREG(NREG), .IDXW(IDXW)) u_rd_dec (
        .idx     (src_d),
        .en      (src_on && !ext_d),
        .out_bar (rd_bar_d)
    );

    onehot_bar_dec #(.NREG(NREG), .IDXW(IDXW)) u_wr_dec (
        .idx     (dst_d),
        .en      (state_d == LATCH),
        .out_bar (wr_bar_d)
    );

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            ext_q        <= 1'b0;
            rd_bar_q     <= STROBE_IDLE[NREG-1:0];
            wr_bar_q     <= STROBE_IDLE[NREG-1:0];
            ext_oe_bar_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            ext_q        <= ext_d;
            rd_bar_q     <= rd_bar_d;
            wr_bar_q     <= wr_bar_d;
            ext_oe_bar_q <= ext_oe_bar_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign rd_bar     = rd_bar_q;
    assign wr_bar     = wr_bar_q;
    assign ext_oe_bar = ext_oe_bar_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule
